// File: rtl/pwm_reg_bank.sv
// pwm_reg_bank
// Memory-mapped control/status register bank for a group of PWM channels.
// It holds channel enables, an interrupt status/enable pair and
// double-buffered (pending/active) period and duty values per channel.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   addr       byte address of the current access
//   wdata      write data
//   wen, ren   single-cycle write / read strobes
//   rdata      registered read data, valid when rvalid=1, holds otherwise
//   rvalid     one-cycle pulse one clock after ren
//   err        one-cycle pulse one clock after an unmapped access
//   status_in  live per-channel status, sampled every cycle
//   evt_in     per-channel event pulses feeding IRQ_STAT
//   upd_in     per-channel period-end strobes that commit pending values
//   ch_en      channel enables (CTRL[NUM_CH-1:0])
//   period_o   active periods, channel n at [n*CNT_WIDTH +: CNT_WIDTH]
//   duty_o     active duties, packed like period_o
//   irq        OR of (IRQ_STAT & IRQ_EN), driven purely from registers
module pwm_reg_bank #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_WIDTH-1:0]       addr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic                        wen,
    input  logic                        ren,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        rvalid,
    output logic                        err,
    input  logic [NUM_CH-1:0]           status_in,
    input  logic [NUM_CH-1:0]           evt_in,
    input  logic [NUM_CH-1:0]           upd_in,
    output logic [NUM_CH-1:0]           ch_en,
    output logic [NUM_CH*CNT_WIDTH-1:0] period_o,
    output logic [NUM_CH*CNT_WIDTH-1:0] duty_o,
    output logic                        irq
);

    localparam int LOAD_BIT = 31;

    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_ISTAT  = ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] A_IEN    = ADDR_WIDTH'(12);

    logic [NUM_CH-1:0]    status_q;
    logic [NUM_CH-1:0]    irq_stat;
    logic [NUM_CH-1:0]    irq_en;
    logic [NUM_CH-1:0]    pend;
    logic [CNT_WIDTH-1:0] per_pend  [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_pend [NUM_CH];
    logic [CNT_WIDTH-1:0] per_act   [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_act  [NUM_CH];

    logic                  hit_ctrl, hit_status, hit_istat, hit_ien;
    logic [NUM_CH-1:0]     hit_per, hit_duty;
    logic                  mapped;
    logic                  load;
    logic [NUM_CH-1:0]     w1c;
    logic [DATA_WIDTH-1:0] read_val;

    // Only the low bits of wdata feed registers; the rest is intentionally dropped.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    // Address decode and read mux. Unmapped addresses (including unaligned
    // ones and channels beyond NUM_CH) match nothing, so read_val stays 0.
    always_comb begin
        hit_ctrl   = (addr == A_CTRL);
        hit_status = (addr == A_STATUS);
        hit_istat  = (addr == A_ISTAT);
        hit_ien    = (addr == A_IEN);
        hit_per    = '0;
        hit_duty   = '0;
        read_val   = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            hit_per[n]  = (addr == ADDR_WIDTH'(16 + 8 * n));
            hit_duty[n] = (addr == ADDR_WIDTH'(20 + 8 * n));
        end
        mapped = hit_ctrl | hit_status | hit_istat | hit_ien | (|hit_per) | (|hit_duty);

        if (hit_ctrl)   read_val = DATA_WIDTH'(ch_en);
        if (hit_status) read_val = DATA_WIDTH'(status_q);
        if (hit_istat)  read_val = DATA_WIDTH'(irq_stat);
        if (hit_ien)    read_val = DATA_WIDTH'(irq_en);
        for (int n = 0; n < NUM_CH; n++) begin
            if (hit_per[n])  read_val = DATA_WIDTH'(per_pend[n]);
            if (hit_duty[n]) read_val = DATA_WIDTH'(duty_pend[n]);
        end

        load = wen && hit_ctrl && wdata[LOAD_BIT];
        w1c  = (wen && hit_istat) ? wdata[NUM_CH-1:0] : '0;
    end

    // All architectural state. Reads sample pre-write values because every
    // register update here is non-blocking. A shadow commit copies the old
    // pending value; a write in the same cycle re-arms pend so the new value
    // waits for the next period end.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_en    <= '0;
            status_q <= '0;
            irq_stat <= '0;
            irq_en   <= '0;
            pend     <= '0;
            rdata    <= '0;
            rvalid   <= 1'b0;
            err      <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) begin
                per_pend[n]  <= '0;
                duty_pend[n] <= '0;
                per_act[n]   <= '0;
                duty_act[n]  <= '0;
            end
        end else begin
            status_q <= status_in;
            rvalid   <= ren;
            err      <= (wen | ren) & ~mapped;
            if (ren) rdata <= read_val;

            if (wen && hit_ctrl) ch_en  <= wdata[NUM_CH-1:0];
            if (wen && hit_ien)  irq_en <= wdata[NUM_CH-1:0];

            // Event set has priority over a simultaneous W1C clear.
            irq_stat <= (irq_stat & ~w1c) | evt_in;

            for (int n = 0; n < NUM_CH; n++) begin
                if (load || (upd_in[n] && pend[n])) begin
                    per_act[n]  <= per_pend[n];
                    duty_act[n] <= duty_pend[n];
                end
                if (wen && hit_per[n])  per_pend[n]  <= wdata[CNT_WIDTH-1:0];
                if (wen && hit_duty[n]) duty_pend[n] <= wdata[CNT_WIDTH-1:0];
                if (wen && (hit_per[n] || hit_duty[n])) begin
                    pend[n] <= 1'b1;
                end else if (load || upd_in[n]) begin
                    pend[n] <= 1'b0;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_pack
            assign period_o[g*CNT_WIDTH +: CNT_WIDTH] = per_act[g];
            assign duty_o[g*CNT_WIDTH +: CNT_WIDTH]   = duty_act[g];
        end
    endgenerate

    assign irq = |(irq_stat & irq_en);

endmodule
